// File: rtl/cmos_dvp_tx.sv
// OV5640-style DVP transmitter: turns an RGB565 pixel stream into vsync/href/byte timing.
// Optional colour-bar source is compiled in with `define DVP_TESTPAT_EN. VBP_LINES and VFP_LINES must be >= 1.
module cmos_dvp_tx #(
  parameter int H_PIXEL   = 640,
  parameter int V_PIXEL   = 480,
  parameter int H_BLANK   = 16,
  parameter int VS_LINES  = 2,
  parameter int VBP_LINES = 4,
  parameter int VFP_LINES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic        test_mode,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        underrun
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFP    = 3'd4;

  localparam logic [12:0] LINE_LAST = 13'(2 * H_PIXEL + H_BLANK - 1);
  localparam logic [12:0] HREF_LEN  = 13'(2 * H_PIXEL);
  localparam logic [11:0] VS_LAST   = 12'(VS_LINES - 1);
  localparam logic [11:0] VBP_LAST  = 12'(VBP_LINES - 1);
  localparam logic [11:0] ACT_LAST  = 12'(V_PIXEL - 1);
  localparam logic [11:0] VFP_LAST  = 12'(VFP_LINES - 1);

  logic [2:0]  state_r, nxt_state_s, follow_s;
  logic [12:0] h_cnt_r, nxt_h_s;
  logic [11:0] v_cnt_r, nxt_v_s, v_last_s;
  logic        line_end_s, frame_end_s, cur_href_s, nxt_ready_s, tp_s;
  logic [15:0] src_pix_s, frame_cnt_r;
  logic [7:0]  cam_data_r, low_byte_r;
  logic        pix_ready_r, vsync_r, href_r, busy_r, underrun_r;

`ifdef DVP_TESTPAT_EN
  logic tp_r;

  function automatic logic [15:0] bar_colour(input logic [11:0] x);
    int bar;
    bar = (int'(x) * 32'sd8) / H_PIXEL;
    case (bar)
      32'sd0:  bar_colour = 16'hFFFF;
      32'sd1:  bar_colour = 16'hFFE0;
      32'sd2:  bar_colour = 16'h07FF;
      32'sd3:  bar_colour = 16'h07E0;
      32'sd4:  bar_colour = 16'hF81F;
      32'sd5:  bar_colour = 16'hF800;
      32'sd6:  bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  // Latch the pixel source at each frame start so a frame never mixes sources.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tp_r <= 1'b0;
    end else if (nxt_state_s == ST_VSYNC && state_r != ST_VSYNC) begin
      tp_r <= test_mode;
    end else begin
      tp_r <= tp_r;
    end
  end

  assign tp_s = tp_r;

  // Pixel source: colour bars or upstream stream (zero on underrun).
  always_comb begin
    src_pix_s = 16'h0000;
    if (tp_r) begin
      src_pix_s = bar_colour(h_cnt_r[12:1]);
    end else if (pix_valid) begin
      src_pix_s = pix_data;
    end else begin
      src_pix_s = 16'h0000;
    end
  end
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode;
  assign tp_s = 1'b0;

  // Pixel source: upstream stream, zero on underrun.
  always_comb begin
    src_pix_s = 16'h0000;
    if (pix_valid) begin
      src_pix_s = pix_data;
    end else begin
      src_pix_s = 16'h0000;
    end
  end
`endif

  // Per-state line count and successor state.
  always_comb begin
    v_last_s = 12'd0;
    follow_s = ST_IDLE;
    case (state_r)
      ST_VSYNC:  begin v_last_s = VS_LAST;  follow_s = ST_VBP;    end
      ST_VBP:    begin v_last_s = VBP_LAST; follow_s = ST_ACTIVE; end
      ST_ACTIVE: begin v_last_s = ACT_LAST; follow_s = ST_VFP;    end
      ST_VFP:    begin v_last_s = VFP_LAST; follow_s = tx_en ? ST_VSYNC : ST_IDLE; end
      default:   begin v_last_s = 12'd0;    follow_s = ST_IDLE;   end
    endcase
  end

  assign line_end_s  = (h_cnt_r == LINE_LAST);
  assign frame_end_s = (state_r == ST_VFP) && line_end_s && (v_cnt_r == v_last_s);
  assign cur_href_s  = (state_r == ST_ACTIVE) && (h_cnt_r < HREF_LEN);

  // Next timing position; outputs are registered from the current position, so they lag it by one cycle.
  always_comb begin
    nxt_state_s = ST_IDLE;
    nxt_h_s     = 13'd0;
    nxt_v_s     = 12'd0;
    case (state_r)
      ST_IDLE: begin
        if (tx_en) begin
          nxt_state_s = ST_VSYNC;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP: begin
        if (!line_end_s) begin
          nxt_state_s = state_r;
          nxt_h_s     = h_cnt_r + 13'd1;
          nxt_v_s     = v_cnt_r;
        end else if (v_cnt_r == v_last_s) begin
          nxt_state_s = follow_s;
        end else begin
          nxt_state_s = state_r;
          nxt_v_s     = v_cnt_r + 12'd1;
        end
      end
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // Ready is raised one cycle ahead, exactly when the next position is a high byte.
  assign nxt_ready_s = (nxt_state_s == ST_ACTIVE) && (nxt_h_s < HREF_LEN) && !nxt_h_s[0] && !tp_s;

  // Timing state and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      h_cnt_r     <= 13'd0;
      v_cnt_r     <= 12'd0;
      busy_r      <= 1'b0;
      vsync_r     <= 1'b0;
      href_r      <= 1'b0;
      pix_ready_r <= 1'b0;
      cam_data_r  <= 8'h00;
      low_byte_r  <= 8'h00;
      frame_cnt_r <= 16'd0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      h_cnt_r     <= nxt_h_s;
      v_cnt_r     <= nxt_v_s;
      busy_r      <= (nxt_state_s != ST_IDLE);
      vsync_r     <= (state_r == ST_VSYNC);
      href_r      <= cur_href_s;
      pix_ready_r <= nxt_ready_s;
      if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (!cur_href_s) begin
        cam_data_r <= 8'h00;
        low_byte_r <= low_byte_r;
      end else if (!h_cnt_r[0]) begin
        cam_data_r <= src_pix_s[15:8];
        low_byte_r <= src_pix_s[7:0];
      end else begin
        cam_data_r <= low_byte_r;
        low_byte_r <= low_byte_r;
      end
      if (pix_ready_r && !pix_valid) begin
        underrun_r <= 1'b1;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  assign pix_ready = pix_ready_r;
  assign cam_vsync = vsync_r;
  assign cam_href  = href_r;
  assign cam_data  = cam_data_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_cnt_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Randomised self-checking bench for cmos_dvp_tx using a frame-arithmetic reference model.
`timescale 1ns/1ps
module tb_cmos_dvp_tx;

  localparam int HP = 4, VP = 2, HB = 3, VS = 1, VBP = 1, VFP = 1;
  localparam int L = 2 * HP + HB;
  localparam int FRAME = (VS + VBP + VP + VFP) * L;
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        test_mode = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_valid = 1'b0;
  logic        pix_ready, cam_vsync, cam_href, busy, underrun;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];
  logic [15:0] cur_pix = 16'h0000;
  logic        ur_model = 1'b0;

  cmos_dvp_tx #(.H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB), .VS_LINES(VS),
                .VBP_LINES(VBP), .VFP_LINES(VFP)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .tx_en(tx_en), .test_mode(test_mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .busy(busy), .frame_cnt(frame_cnt), .underrun(underrun));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bar_of(input int x);
    logic [15:0] tbl [8];
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return tbl[(x * 8) / HP];
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1; tx_en = 1'b0; pix_valid = 1'b0; test_mode = 1'b0;
    tick();
    sys_rst = 1'b0;
    q.delete();
    ur_model = 1'b0;
    cur_pix = 16'h0000;
  endtask

  // From IDLE: raise tx_en; after return the next observed cycle is frame cycle k=0.
  task automatic start_frames(input logic tp);
    test_mode = tp;
    tx_en = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    tick();
  endtask

  // Cycle-by-cycle comparison against frame arithmetic; vmode 0=always valid, 1=3rd acceptance invalid, 2=random.
  task automatic run_model(input int k0, input int n, input int end_k, input int drop_k,
                           input int vmode, input logic tp, input int base_fc, output int n_acc);
    n_acc = 0;
    for (int k = k0; k < k0 + n; k++) begin
      int f, ln, hx, f1, ln1, hx1;
      bit e_href, e_vs, e_rdy, e_busy, v;
      logic [7:0] e_byte;
      logic [15:0] e_fc;
      f = k % FRAME;   ln = f / L - VS - VBP;   hx = f % L;
      f1 = (k + 1) % FRAME; ln1 = f1 / L - VS - VBP; hx1 = f1 % L;
      e_href = (ln >= 0) && (ln < VP) && (hx < 2 * HP);
      e_vs   = (f < VS * L);
      e_rdy  = !tp && (k + 1 < end_k) && (ln1 >= 0) && (ln1 < VP) && (hx1 < 2 * HP) && (hx1 % 2 == 0);
      e_busy = (k + 1 < end_k);
      e_fc   = 16'(base_fc + (k + 1) / FRAME);
      e_byte = 8'h00;
      if (e_href && (hx % 2 == 0)) begin
        if (tp) begin
          cur_pix = bar_of(hx / 2);
        end else if (q.size() > 0) begin
          cur_pix = q.pop_front();
        end else begin
          cur_pix = 16'h0000;
          errors++; checks++;
          $display("FAIL pixel_queue k=%0d got=empty exp=accepted pixel", k);
        end
        e_byte = cur_pix[15:8];
      end else if (e_href) begin
        e_byte = cur_pix[7:0];
      end
      checks += 8;
      if (cam_vsync !== e_vs)   begin errors++; $display("FAIL vsync k=%0d got=%b exp=%b", k, cam_vsync, e_vs); end
      if (cam_href !== e_href)  begin errors++; $display("FAIL href k=%0d got=%b exp=%b", k, cam_href, e_href); end
      if (cam_data !== e_byte)  begin errors++; $display("FAIL data k=%0d got=%h exp=%h", k, cam_data, e_byte); end
      if (pix_ready !== e_rdy)  begin errors++; $display("FAIL ready k=%0d got=%b exp=%b", k, pix_ready, e_rdy); end
      if (busy !== e_busy)      begin errors++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, e_busy); end
      if (frame_cnt !== e_fc)   begin errors++; $display("FAIL frame_cnt k=%0d got=%0d exp=%0d", k, frame_cnt, e_fc); end
      if (underrun !== ur_model) begin errors++; $display("FAIL underrun k=%0d got=%b exp=%b", k, underrun, ur_model); end
      if (cam_vsync === 1'b1 && cam_href === 1'b1) begin errors++; $display("FAIL vs_href_overlap k=%0d got=1 exp=0", k); end
      // Drive next cycle's inputs; an acceptance happens at the coming edge when pix_ready is high now.
      if (k == drop_k) tx_en = 1'b0;
      pix_data = 16'($urandom);
      case (vmode)
        0: v = 1'b1;
        1: v = (n_acc != 2);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      pix_valid = v;
      if (pix_ready === 1'b1) begin
        q.push_back(v ? pix_data : 16'h0000);
        if (!v) ur_model = 1'b1;
        n_acc++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (cam_vsync !== 1'b0) begin errors++; $display("FAIL rst_vsync got=%b exp=0", cam_vsync); end
    if (cam_href !== 1'b0)  begin errors++; $display("FAIL rst_href got=%b exp=0", cam_href); end
    if (cam_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", cam_data); end
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", pix_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    if (underrun !== 1'b0)  begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_frame_timing();
    int acc;
    do_reset();
    start_frames(1'b0);
    run_model(0, 2 * FRAME, NEVER, -1, 0, 1'b0, 0, acc);
    checks++;
    if (acc !== 2 * HP * VP) begin errors++; $display("FAIL accept_count got=%0d exp=%0d", acc, 2 * HP * VP); end
  endtask

  task automatic test_underrun();
    int acc;
    do_reset();
    start_frames(1'b0);
    run_model(0, FRAME, NEVER, -1, 1, 1'b0, 0, acc);
    checks++;
    if (ur_model !== 1'b1 || underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    run_model(FRAME, FRAME, NEVER, -1, 0, 1'b0, 0, acc);
    do_reset();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
  endtask

  task automatic test_tx_en_drop();
    int acc;
    do_reset();
    start_frames(1'b0);
    run_model(0, 2 * FRAME, 2 * FRAME, FRAME + (VS + VBP) * L + 1, 2, 1'b0, 0, acc);
    for (int i = 0; i < 5; i++) begin
      checks += 5;
      if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy i=%0d got=%b exp=0", i, busy); end
      if (cam_vsync !== 1'b0 || cam_href !== 1'b0) begin errors++; $display("FAIL idle_sync i=%0d got=%b%b exp=00", i, cam_vsync, cam_href); end
      if (cam_data !== 8'h00)  begin errors++; $display("FAIL idle_data i=%0d got=%h exp=00", i, cam_data); end
      if (pix_ready !== 1'b0)  begin errors++; $display("FAIL idle_ready i=%0d got=%b exp=0", i, pix_ready); end
      if (frame_cnt !== 16'd2) begin errors++; $display("FAIL idle_frame_cnt i=%0d got=%0d exp=2", i, frame_cnt); end
      tick();
    end
  endtask

  task automatic test_sys_rst_midframe();
    int acc;
    do_reset();
    start_frames(1'b0);
    run_model(0, (VS + VBP) * L + 4, NEVER, -1, 0, 1'b0, 0, acc);
    sys_rst = 1'b1;
    tick();
    checks += 5;
    if (cam_vsync !== 1'b0 || cam_href !== 1'b0) begin errors++; $display("FAIL srst_sync got=%b%b exp=00", cam_vsync, cam_href); end
    if (cam_data !== 8'h00)  begin errors++; $display("FAIL srst_data got=%h exp=00", cam_data); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL srst_frame_cnt got=%0d exp=0", frame_cnt); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL srst_busy got=%b exp=0", busy); end
    if (pix_ready !== 1'b0)  begin errors++; $display("FAIL srst_ready got=%b exp=0", pix_ready); end
    sys_rst = 1'b0;
    q.delete();
    ur_model = 1'b0;
    start_frames(1'b0);
    run_model(0, FRAME + 2, NEVER, -1, 2, 1'b0, 0, acc);
  endtask

`ifdef DVP_TESTPAT_EN
  task automatic test_testpat();
    int acc;
    do_reset();
    start_frames(1'b1);
    run_model(0, FRAME, NEVER, -1, 0, 1'b1, 0, acc);
    checks++;
    if (acc !== 0) begin errors++; $display("FAIL testpat_ready got=%0d exp=0", acc); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_timing();
    test_underrun();
    test_tx_en_drop();
    test_sys_rst_midframe();
`ifdef DVP_TESTPAT_EN
    test_testpat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
